fetch_stream_queue: RTL and testbench

//  Consumer end of BpuFsqIO: stores BPU stream predictions in a circular queue and serves them to the IFU.

---
 rtl/fetch_stream_queue_pkg.sv | 77 +++++++
 rtl/fetch_stream_queue_if.sv | 30 +++
 rtl/fetch_stream_queue_ptr_ctrl.sv | 24 ++
 rtl/fetch_stream_queue.sv | 174 +++++++++++++++++
 tb/tb_fetch_stream_queue.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stream_queue_pkg.sv
// Shared types and constants for the fetch stream queue: pointers, stream records, BPU
// prediction/update payloads.
`timescale 1ns/1ps
package fetch_stream_queue_pkg;

    localparam int FSQ_SIZE  = 16;
    localparam int FSQ_IDX_W = $clog2(FSQ_SIZE);
    localparam int VADDR_W   = 32;
    localparam int SIZE_W    = 5;
    localparam logic [FSQ_IDX_W:0] FSQ_SPAN = (FSQ_IDX_W + 1)'(FSQ_SIZE);

    typedef enum logic [1:0] {
        BR_NONE,
        BR_COND,
        BR_JUMP,
        BR_RET
    } branch_type_e;

    typedef struct packed {
        logic                 dir;
        logic [FSQ_IDX_W-1:0] idx;
    } fsq_ptr_t;

    typedef struct packed {
        logic [VADDR_W-1:0] start_addr;
        logic [VADDR_W-1:0] target;
        logic [SIZE_W-1:0]  size;
        logic               taken;
        branch_type_e       branch_type;
    } branch_stream_t;

    typedef struct packed {
        branch_stream_t       stream;
        logic [FSQ_IDX_W-1:0] stream_idx;
        logic                 stream_dir;
    } prediction_result_t;

    typedef struct packed {
        logic [7:0]  ubtb_meta;
        logic [23:0] tage_meta;
    } prediction_meta_t;

    typedef struct packed {
        logic [VADDR_W-1:0] target_pc;
    } squash_info_t;

    typedef struct packed {
        branch_stream_t     stream;
        prediction_meta_t   meta;
        logic               taken;
        logic [VADDR_W-1:0] target;
    } branch_update_info_t;

    typedef struct packed {
        logic [VADDR_W-1:0]   start_addr;
        logic [SIZE_W-1:0]    size;
        logic [VADDR_W-1:0]   target;
        logic [FSQ_IDX_W-1:0] fsq_idx;
    } fetch_stream_t;

    // The flat {dir,idx} increment wraps idx and toggles dir because FSQ_SIZE is a power of two.
    function automatic fsq_ptr_t ptr_inc(input fsq_ptr_t p);
        logic [FSQ_IDX_W:0] flat;
        flat = p;
        flat = flat + 1'b1;
        return fsq_ptr_t'(flat);
    endfunction

    function automatic logic [FSQ_IDX_W:0] ptr_dist(input fsq_ptr_t ahead, input fsq_ptr_t behind);
        logic [FSQ_IDX_W:0] a;
        logic [FSQ_IDX_W:0] b;
        a = ahead;
        b = behind;
        return a - b;
    endfunction

endpackage

// File: rtl/fetch_stream_queue_if.sv
// BPU <-> fetch stream queue bundle: predictions and s2 meta in, stall/squash/update back.
`timescale 1ns/1ps
interface fetch_stream_queue_if;
    import fetch_stream_queue_pkg::*;

    logic                 en;
    prediction_result_t   prediction;
    logic                 redirect;
    logic                 lastStage;
    logic [FSQ_IDX_W-1:0] lastStageIdx;
    prediction_meta_t     lastStageMeta;
    logic                 stall;
    logic [FSQ_IDX_W-1:0] stream_idx;
    logic                 stream_dir;
    logic                 squash;
    squash_info_t         squashInfo;
    logic                 update;
    branch_update_info_t  updateInfo;

    modport master (
        output en, prediction, redirect, lastStage, lastStageIdx, lastStageMeta,
        input  stall, stream_idx, stream_dir, squash, squashInfo, update, updateInfo
    );

    modport slave (
        input  en, prediction, redirect, lastStage, lastStageIdx, lastStageMeta,
        output stall, stream_idx, stream_dir, squash, squashInfo, update, updateInfo
    );

endinterface

// File: rtl/fetch_stream_queue_ptr_ctrl.sv
// One {dir,idx} queue pointer: load has priority over increment.
`timescale 1ns/1ps
module fsq_ptr_ctrl
    import fetch_stream_queue_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     inc,
    input  logic     load,
    input  fsq_ptr_t load_val,
    output fsq_ptr_t ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr_inc(ptr);
        end
    end

endmodule

// File: rtl/fetch_stream_queue.sv
// Circular queue of BPU fetch streams served to the IFU, with s2 overrides, backend redirects
// and commit-time BPU updates. Define FSQ_PERF_EN to add saturating performance counters.
`timescale 1ns/1ps
module fetch_stream_queue
    import fetch_stream_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fetch_stream_queue_if.slave  bpu_fsq_io,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output fetch_stream_t        fetch_stream,
    output logic                 fetch_flush,
    input  logic                 be_redirect_valid,
    input  logic [FSQ_IDX_W-1:0] be_redirect_idx,
    input  logic [VADDR_W-1:0]   be_redirect_pc,
    input  logic                 commit_valid,
    input  logic                 commit_taken,
    input  logic [VADDR_W-1:0]   commit_target
`ifdef FSQ_PERF_EN
    ,
    output logic [31:0]          perf_full_cycles,
    output logic [31:0]          perf_s2_redirects,
    output logic [31:0]          perf_be_redirects
`endif
);

    fsq_ptr_t write_ptr;
    fsq_ptr_t search_ptr;
    fsq_ptr_t commit_ptr;
    fsq_ptr_t s2_ptr;
    fsq_ptr_t be_ptr;
    fsq_ptr_t redirect_next;
    logic [FSQ_IDX_W:0] s2_dist;
    logic full;
    logic fetch_fire;
    logic enq;
    logic s2_override;
    logic s2_rewind;
    logic commit_fire;

    branch_stream_t   entries [FSQ_SIZE];
    prediction_meta_t metas   [FSQ_SIZE];

    logic                squash_q;
    squash_info_t        squash_info_q;
    logic                update_q;
    branch_update_info_t update_info_q;

    assign full        = (write_ptr.idx == commit_ptr.idx) && (write_ptr.dir != commit_ptr.dir);
    assign fetch_valid = (search_ptr != write_ptr) && !fetch_flush;
    assign fetch_fire  = fetch_valid && fetch_ready;
    assign commit_fire = commit_valid && (commit_ptr != search_ptr);
    assign s2_override = bpu_fsq_io.en && bpu_fsq_io.redirect && !be_redirect_valid;
    assign enq         = bpu_fsq_io.en && !bpu_fsq_io.redirect && !full && !be_redirect_valid;

    assign s2_ptr  = '{dir: bpu_fsq_io.prediction.stream_dir, idx: bpu_fsq_io.prediction.stream_idx};
    assign s2_dist = ptr_dist(search_ptr, s2_ptr);
    // A stream being fetched in the same cycle it is overridden counts as already passed.
    assign s2_rewind = s2_override &&
                       (((s2_dist != '0) && (s2_dist <= FSQ_SPAN)) || ((s2_dist == '0) && fetch_fire));

    // Backend only names an idx; entries below the commit idx belong to the next lap.
    assign be_ptr = '{dir: (be_redirect_idx >= commit_ptr.idx) ? commit_ptr.dir : ~commit_ptr.dir,
                      idx: be_redirect_idx};
    assign redirect_next = be_redirect_valid ? ptr_inc(be_ptr) : ptr_inc(s2_ptr);

    fsq_ptr_ctrl u_write_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (enq),
        .load     (be_redirect_valid || s2_override),
        .load_val (redirect_next),
        .ptr      (write_ptr)
    );

    fsq_ptr_ctrl u_search_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (fetch_fire),
        .load     (be_redirect_valid || s2_rewind),
        .load_val (be_redirect_valid ? redirect_next : s2_ptr),
        .ptr      (search_ptr)
    );

    fsq_ptr_ctrl u_commit_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (commit_fire),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (commit_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FSQ_SIZE; i++) begin
                entries[i] <= '0;
                metas[i]   <= '0;
            end
        end else begin
            if (be_redirect_valid) begin
                entries[be_redirect_idx].target <= be_redirect_pc;
            end else if (s2_override) begin
                entries[s2_ptr.idx] <= bpu_fsq_io.prediction.stream;
            end else if (enq) begin
                entries[write_ptr.idx] <= bpu_fsq_io.prediction.stream;
            end
            if (bpu_fsq_io.lastStage) begin
                metas[bpu_fsq_io.lastStageIdx] <= bpu_fsq_io.lastStageMeta;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            squash_q      <= 1'b0;
            squash_info_q <= '0;
            fetch_flush   <= 1'b0;
            update_q      <= 1'b0;
            update_info_q <= '0;
        end else begin
            squash_q    <= be_redirect_valid;
            fetch_flush <= be_redirect_valid || s2_rewind;
            update_q    <= commit_fire;
            if (be_redirect_valid) begin
                squash_info_q.target_pc <= be_redirect_pc;
            end
            if (commit_fire) begin
                update_info_q <= '{stream: entries[commit_ptr.idx],
                                   meta:   metas[commit_ptr.idx],
                                   taken:  commit_taken,
                                   target: commit_target};
            end
        end
    end

    assign fetch_stream = '{start_addr: entries[search_ptr.idx].start_addr,
                            size:       entries[search_ptr.idx].size,
                            target:     entries[search_ptr.idx].target,
                            fsq_idx:    search_ptr.idx};

    assign bpu_fsq_io.stall      = full;
    assign bpu_fsq_io.stream_idx = write_ptr.idx;
    assign bpu_fsq_io.stream_dir = write_ptr.dir;
    assign bpu_fsq_io.squash     = squash_q;
    assign bpu_fsq_io.squashInfo = squash_info_q;
    assign bpu_fsq_io.update     = update_q;
    assign bpu_fsq_io.updateInfo = update_info_q;

    commit_on_empty: assert property (@(posedge clk) disable iff (rst)
        !(commit_valid && (commit_ptr == search_ptr)));

`ifdef FSQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_cycles  <= '0;
            perf_s2_redirects <= '0;
            perf_be_redirects <= '0;
        end else begin
            if (full && (perf_full_cycles != '1)) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if (s2_override && (perf_s2_redirects != '1)) begin
                perf_s2_redirects <= perf_s2_redirects + 32'd1;
            end
            if (be_redirect_valid && (perf_be_redirects != '1)) begin
                perf_be_redirects <= perf_be_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stream_queue.sv
// Directed self-checking bench for fetch_stream_queue: fill/stall, s2 override, backend
// redirect, commit updates, full-queue commit, pointer wrap and mid-operation reset.
`timescale 1ns/1ps
module tb_fetch_stream_queue;
    import fetch_stream_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic fetch_valid;
    logic fetch_ready;
    fetch_stream_t fetch_stream;
    logic fetch_flush;
    logic be_redirect_valid;
    logic [FSQ_IDX_W-1:0] be_redirect_idx;
    logic [VADDR_W-1:0] be_redirect_pc;
    logic commit_valid;
    logic commit_taken;
    logic [VADDR_W-1:0] commit_target;
`ifdef FSQ_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_s2_redirects;
    logic [31:0] perf_be_redirects;
`endif

    int compare_count = 0;
    int mismatch_count = 0;

    fetch_stream_queue_if bpu_fsq_io();

    always #5 clk = ~clk;

    fetch_stream_queue dut (
        .clk               (clk),
        .rst               (rst),
        .bpu_fsq_io        (bpu_fsq_io),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_stream      (fetch_stream),
        .fetch_flush       (fetch_flush),
        .be_redirect_valid (be_redirect_valid),
        .be_redirect_idx   (be_redirect_idx),
        .be_redirect_pc    (be_redirect_pc),
        .commit_valid      (commit_valid),
        .commit_taken      (commit_taken),
        .commit_target     (commit_target)
`ifdef FSQ_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_s2_redirects (perf_s2_redirects),
        .perf_be_redirects (perf_be_redirects)
`endif
    );

    function automatic logic [31:0] streamAddr(input int n);
        return 32'h9000_0000 + 32'(n) * 32'h40;
    endfunction

    function automatic logic [31:0] targetAddr(input int n);
        return 32'h4000_0000 + 32'(n) * 32'h100;
    endfunction

    task automatic applyStimulus(input int cycles = 1);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bpu_fsq_io.en            = 1'b0;
        bpu_fsq_io.prediction    = '0;
        bpu_fsq_io.redirect      = 1'b0;
        bpu_fsq_io.lastStage     = 1'b0;
        bpu_fsq_io.lastStageIdx  = '0;
        bpu_fsq_io.lastStageMeta = '0;
        fetch_ready       = 1'b0;
        be_redirect_valid = 1'b0;
        be_redirect_idx   = '0;
        be_redirect_pc    = '0;
        commit_valid      = 1'b0;
        commit_taken      = 1'b0;
        commit_target     = '0;
    endtask

    task automatic resetDut();
        idleInputs();
        rst = 1'b1;
        applyStimulus(2);
        rst = 1'b0;
    endtask

    task automatic setStream(input logic [31:0] start_addr, input logic [31:0] target);
        bpu_fsq_io.prediction.stream.start_addr  = start_addr;
        bpu_fsq_io.prediction.stream.target      = target;
        bpu_fsq_io.prediction.stream.size        = 5'd16;
        bpu_fsq_io.prediction.stream.taken       = 1'b1;
        bpu_fsq_io.prediction.stream.branch_type = BR_COND;
    endtask

    task automatic enqueueStream(input logic [31:0] start_addr, input logic [31:0] target);
        setStream(start_addr, target);
        bpu_fsq_io.en       = 1'b1;
        bpu_fsq_io.redirect = 1'b0;
        applyStimulus();
        bpu_fsq_io.en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fill to stall; the 17th prediction must be dropped.
        resetDut();
        checkOutput("rst_stall", bpu_fsq_io.stall, 0);
        checkOutput("rst_stream_idx", bpu_fsq_io.stream_idx, 0);
        checkOutput("rst_stream_dir", bpu_fsq_io.stream_dir, 0);
        checkOutput("rst_fetch_valid", fetch_valid, 0);
        checkOutput("rst_fetch_flush", fetch_flush, 0);
        checkOutput("rst_squash", bpu_fsq_io.squash, 0);
        checkOutput("rst_update", bpu_fsq_io.update, 0);
        checkOutput("rst_fetch_start", fetch_stream.start_addr, 0);
        for (int i = 0; i < 16; i++) begin
            enqueueStream(streamAddr(i), targetAddr(i));
            if (i == 14) checkOutput("t1_stall_at_15", bpu_fsq_io.stall, 0);
        end
        checkOutput("t1_stall_full", bpu_fsq_io.stall, 1);
        checkOutput("t1_idx_full", bpu_fsq_io.stream_idx, 0);
        checkOutput("t1_dir_full", bpu_fsq_io.stream_dir, 1);
        enqueueStream(32'hDEAD_BEE0, 32'h1111_0000);
        checkOutput("t1_stall_17", bpu_fsq_io.stall, 1);
        checkOutput("t1_idx_17", bpu_fsq_io.stream_idx, 0);
        checkOutput("t1_dir_17", bpu_fsq_io.stream_dir, 1);
        checkOutput("t1_fetch_valid", fetch_valid, 1);
        checkOutput("t1_entry0_kept", fetch_stream.start_addr, streamAddr(0));

        // s2 override of an already-fetched entry rewinds search and flushes the IFU.
        resetDut();
        for (int i = 0; i < 4; i++) enqueueStream(streamAddr(i), targetAddr(i));
        fetch_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_fetch_idx", fetch_stream.fsq_idx, i);
            applyStimulus();
        end
        checkOutput("t2_drained", fetch_valid, 0);
        setStream(streamAddr(2), 32'h8000_1000);
        bpu_fsq_io.prediction.stream_idx = 4'd2;
        bpu_fsq_io.prediction.stream_dir = 1'b0;
        bpu_fsq_io.en       = 1'b1;
        bpu_fsq_io.redirect = 1'b1;
        applyStimulus();
        bpu_fsq_io.en       = 1'b0;
        bpu_fsq_io.redirect = 1'b0;
        checkOutput("t2_flush", fetch_flush, 1);
        checkOutput("t2_write_idx", bpu_fsq_io.stream_idx, 3);
        checkOutput("t2_valid_in_flush", fetch_valid, 0);
        applyStimulus();
        checkOutput("t2_flush_cleared", fetch_flush, 0);
        checkOutput("t2_refetch_valid", fetch_valid, 1);
        checkOutput("t2_refetch_idx", fetch_stream.fsq_idx, 2);
        checkOutput("t2_refetch_target", fetch_stream.target, 32'h8000_1000);
        applyStimulus();
        checkOutput("t2_after_refetch", fetch_valid, 0);
        fetch_ready = 1'b0;

        // Backend redirect wins over a same-cycle s2 override.
        resetDut();
        for (int i = 0; i < 8; i++) enqueueStream(streamAddr(i), targetAddr(i));
        be_redirect_valid = 1'b1;
        be_redirect_idx   = 4'd5;
        be_redirect_pc    = 32'h8000_2000;
        setStream(streamAddr(3), 32'h1234_5678);
        bpu_fsq_io.prediction.stream_idx = 4'd3;
        bpu_fsq_io.prediction.stream_dir = 1'b0;
        bpu_fsq_io.en       = 1'b1;
        bpu_fsq_io.redirect = 1'b1;
        applyStimulus();
        idleInputs();
        checkOutput("t3_squash", bpu_fsq_io.squash, 1);
        checkOutput("t3_squash_pc", bpu_fsq_io.squashInfo.target_pc, 32'h8000_2000);
        checkOutput("t3_flush", fetch_flush, 1);
        checkOutput("t3_write_idx", bpu_fsq_io.stream_idx, 6);
        checkOutput("t3_write_dir", bpu_fsq_io.stream_dir, 0);
        applyStimulus();
        checkOutput("t3_squash_pulse", bpu_fsq_io.squash, 0);
        checkOutput("t3_flush_pulse", fetch_flush, 0);
        checkOutput("t3_search_eq_write", fetch_valid, 0);
        commit_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            if (i == 3) checkOutput("t3_entry3_target", bpu_fsq_io.updateInfo.stream.target, targetAddr(3));
            if (i == 5) begin
                checkOutput("t3_update5", bpu_fsq_io.update, 1);
                checkOutput("t3_entry5_target", bpu_fsq_io.updateInfo.stream.target, 32'h8000_2000);
            end
        end
        commit_valid = 1'b0;

        // s2 meta for idx7 arrives alongside an enqueue and is reported at its commit.
        resetDut();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                bpu_fsq_io.lastStage     = 1'b1;
                bpu_fsq_io.lastStageIdx  = 4'd7;
                bpu_fsq_io.lastStageMeta = '{ubtb_meta: 8'hA5, tage_meta: 24'h5AC33C};
            end
            enqueueStream(streamAddr(i), targetAddr(i));
            bpu_fsq_io.lastStage = 1'b0;
        end
        fetch_ready = 1'b1;
        applyStimulus(9);
        fetch_ready   = 1'b0;
        commit_valid  = 1'b1;
        commit_taken  = 1'b1;
        commit_target = 32'h8000_3000;
        applyStimulus(8);
        commit_valid = 1'b0;
        checkOutput("t4_update", bpu_fsq_io.update, 1);
        checkOutput("t4_meta", bpu_fsq_io.updateInfo.meta, 32'hA55A_C33C);
        checkOutput("t4_taken", bpu_fsq_io.updateInfo.taken, 1);
        checkOutput("t4_target", bpu_fsq_io.updateInfo.target, 32'h8000_3000);
        checkOutput("t4_start", bpu_fsq_io.updateInfo.stream.start_addr, streamAddr(7));
        applyStimulus();
        checkOutput("t4_update_pulse", bpu_fsq_io.update, 0);

        // Commit and enqueue together on a full queue: enqueue deferred one cycle.
        resetDut();
        for (int i = 0; i < 16; i++) enqueueStream(streamAddr(i), targetAddr(i));
        fetch_ready = 1'b1;
        applyStimulus();
        fetch_ready  = 1'b0;
        commit_valid = 1'b1;
        enqueueStream(32'hDEAD_0000, 32'h2222_0000);
        commit_valid = 1'b0;
        checkOutput("t5_stall_drop", bpu_fsq_io.stall, 0);
        checkOutput("t5_no_enq_idx", bpu_fsq_io.stream_idx, 0);
        checkOutput("t5_no_enq_dir", bpu_fsq_io.stream_dir, 1);
        enqueueStream(32'hBEEF_0000, 32'h3333_0000);
        checkOutput("t5_enq_idx", bpu_fsq_io.stream_idx, 1);
        checkOutput("t5_full_again", bpu_fsq_io.stall, 1);
        fetch_ready = 1'b1;
        applyStimulus(15);
        fetch_ready = 1'b0;
        checkOutput("t5_reuse_idx", fetch_stream.fsq_idx, 0);
        checkOutput("t5_reuse_start", fetch_stream.start_addr, 32'hBEEF_0000);

        // Steady enqueue/fetch/commit flow across two pointer wraps.
        resetDut();
        for (int i = 0; i < 40; i++) begin
            setStream(streamAddr(i), targetAddr(i));
            bpu_fsq_io.en = 1'b1;
            fetch_ready   = 1'b1;
            commit_valid  = (i >= 2);
            applyStimulus();
            if (i == 15) begin
                checkOutput("t6_wrap1_idx", bpu_fsq_io.stream_idx, 0);
                checkOutput("t6_wrap1_dir", bpu_fsq_io.stream_dir, 1);
            end
            if (i == 31) begin
                checkOutput("t6_wrap2_idx", bpu_fsq_io.stream_idx, 0);
                checkOutput("t6_wrap2_dir", bpu_fsq_io.stream_dir, 0);
            end
        end
        idleInputs();
        checkOutput("t6_end_idx", bpu_fsq_io.stream_idx, 8);
        checkOutput("t6_end_dir", bpu_fsq_io.stream_dir, 0);
        checkOutput("t6_update", bpu_fsq_io.update, 1);
        checkOutput("t6_update_start", bpu_fsq_io.updateInfo.stream.start_addr, streamAddr(37));

        // Reset on the same edge as a backend redirect leaves no pending squash.
        resetDut();
        for (int i = 0; i < 3; i++) enqueueStream(streamAddr(i), targetAddr(i));
        be_redirect_valid = 1'b1;
        be_redirect_idx   = 4'd1;
        be_redirect_pc    = 32'h8000_4000;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        idleInputs();
        checkOutput("t7_squash", bpu_fsq_io.squash, 0);
        checkOutput("t7_flush", fetch_flush, 0);
        checkOutput("t7_write_idx", bpu_fsq_io.stream_idx, 0);
        checkOutput("t7_fetch_valid", fetch_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
